// File: rtl/fm_ctrl_gen.sv
// ---------------------------------------------------------------------------
// fm_ctrl_gen
//
// FM frequency-control generator for the NCO. Each accepted signed 8-bit
// modulating sample produces a new frequency word target = carrier + sample*dev
// (mod 2^32). The ctrl output slews linearly from its current value to that
// target over 2^RAMP_LOG2 clocks. This avoids step jumps in the NCO's
// instantaneous frequency.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-low reset
//   carrier  in   [31:0] carrier frequency word, latched on accept
//   dev      in   [23:0] deviation gain, latched on accept
//   s_data   in   [7:0]  signed modulating sample
//   s_valid  in   sample valid
//   s_ready  out  high in IDLE (combinational from state)
//   ctrl     out  [31:0] registered frequency word to the NCO
//   busy     out  high whenever not IDLE
// ---------------------------------------------------------------------------
module fm_ctrl_gen #(
    parameter int RAMP_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] carrier,
    input  logic [23:0] dev,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] ctrl,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        CALC = 2'd2,
        RAMP = 2'd3
    } state_t;

    // Index of the final ramp edge, on which ctrl snaps to target.
    localparam logic [8:0] CNT_LAST = 9'((1 << RAMP_LOG2) - 1);

    state_t      state;
    logic [7:0]  data_lat;
    logic [31:0] carrier_lat;
    logic [23:0] dev_lat;
    logic [31:0] prod;
    logic [31:0] target;
    logic [31:0] step;
    logic [8:0]  cnt;

    logic [31:0]        prod_next;
    logic [31:0]        target_next;
    logic signed [32:0] diff_next;
    logic [31:0]        step_next;

    // Both operands are extended to 32 bits. |sample*dev| < 2^31, so the
    // 32-bit two's-complement product is exact.
    assign prod_next   = $signed({{24{data_lat[7]}}, data_lat}) * $signed({8'b0, dev_lat});
    assign target_next = carrier_lat + prod;
    // The ramp travels the true 33-bit signed distance, not the shortest
    // circular path around the 2^32 phase-increment space.
    assign diff_next   = $signed({1'b0, target_next}) - $signed({1'b0, ctrl});
    assign step_next   = 32'(diff_next >>> RAMP_LOG2);

    assign s_ready = (state == IDLE);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            data_lat    <= '0;
            carrier_lat <= '0;
            dev_lat     <= '0;
            prod        <= '0;
            target      <= '0;
            step        <= '0;
            cnt         <= '0;
            ctrl        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        data_lat    <= s_data;
                        carrier_lat <= carrier;
                        dev_lat     <= dev;
                        state       <= MULT;
                    end
                end
                MULT: begin
                    prod  <= prod_next;
                    state <= CALC;
                end
                CALC: begin
                    target <= target_next;
                    step   <= step_next;
                    cnt    <= '0;
                    state  <= RAMP;
                end
                RAMP: begin
                    cnt <= cnt + 9'd1;
                    if (cnt == CNT_LAST) begin
                        // Land exactly on target; drop the truncation residue of step.
                        ctrl  <= target;
                        state <= IDLE;
                    end else begin
                        ctrl <= ctrl + step;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fm_ctrl_gen.sv
module tb_fm_ctrl_gen;

    localparam int R     = 4;
    localparam int NSTEP = 1 << R;

    logic        clk;
    logic        rst;

    // DUT A: default RAMP_LOG2=4
    logic [31:0] a_carrier;
    logic [23:0] a_dev;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_ctrl;
    logic        a_busy;

    // DUT B: RAMP_LOG2=0
    logic [31:0] b_carrier;
    logic [23:0] b_dev;
    logic [7:0]  b_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_ctrl;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic [31:0] model_ctrl;

    fm_ctrl_gen #(.RAMP_LOG2(R)) dut_a (
        .clk(clk), .rst(rst),
        .carrier(a_carrier), .dev(a_dev), .s_data(a_data), .s_valid(a_valid),
        .s_ready(a_ready), .ctrl(a_ctrl), .busy(a_busy)
    );

    fm_ctrl_gen #(.RAMP_LOG2(0)) dut_b (
        .clk(clk), .rst(rst),
        .carrier(b_carrier), .dev(b_dev), .s_data(b_data), .s_valid(b_valid),
        .s_ready(b_ready), .ctrl(b_ctrl), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] calc_target(input logic [31:0] car, input logic [23:0] dv,
                                                input logic [7:0] d);
        longint sd;
        longint dl;
        sd = longint'($signed(d));
        dl = longint'({40'b0, dv});
        return 32'(longint'({32'b0, car}) + sd * dl);
    endfunction

    function automatic logic [31:0] calc_step(input logic [31:0] tgt, input logic [31:0] start,
                                              input int r);
        logic signed [32:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, start});
        return 32'(diff >>> r);
    endfunction

    task automatic sb_check(input string name, input logic [31:0] got);
        logic [31:0] exp_v;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got ctrl %h but no expected entry", name, got);
        end else begin
            exp_v = sb_q.pop_front();
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s final ctrl: got %h expected %h", name, got, exp_v);
            end else
                $display("PASS %s final ctrl %h", name, got);
        end
    endtask

    task automatic wait_ready_a(input string name);
        for (int i = 0; i < 100 && a_ready !== 1'b1; i++) tick();
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s wait s_ready: got %b expected 1", name, a_ready);
        end
    endtask

    // Accepts one sample on DUT A and checks ctrl at every edge through E(2+2^R).
    task automatic do_sample(input logic [31:0] car, input logic [23:0] dv, input logic [7:0] d,
                             input string name);
        logic [31:0] tgt, stp, start, expv;
        wait_ready_a(name);
        start = model_ctrl;
        tgt   = calc_target(car, dv, d);
        stp   = calc_step(tgt, start, R);
        sb_q.push_back(tgt);
        a_carrier = car; a_dev = dv; a_data = d; a_valid = 1'b1;
        tick();                                // E0
        a_valid = 1'b0;
        // Changes while busy must not affect this sample.
        a_carrier = $urandom; a_dev = 24'($urandom); a_data = 8'($urandom);
        checks++;
        if (a_busy !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s after accept: busy=%b s_ready=%b expected busy=1 s_ready=0",
                     name, a_busy, a_ready);
        end
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (a_ctrl !== start) begin
                errors++;
                $display("FAIL %s ctrl E%0d: got %h expected %h", name, e, a_ctrl, start);
            end
        end
        for (int k = 1; k <= NSTEP; k++) begin
            tick();
            expv = (k == NSTEP) ? tgt : start + 32'(k) * stp;
            checks++;
            if (a_ctrl !== expv) begin
                errors++;
                $display("FAIL %s ctrl E%0d: got %h expected %h", name, k + 2, a_ctrl, expv);
            end
        end
        checks++;
        if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after ramp: s_ready=%b busy=%b expected 1/0", name, a_ready, a_busy);
        end
        sb_check(name, a_ctrl);
        model_ctrl = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b0; a_carrier = '0; a_dev = '0; a_data = '0;
        b_valid = 1'b0; b_carrier = '0; b_dev = '0; b_data = '0;
        tick(); tick(); tick();
        checks++;
        if (a_ctrl !== 32'h0 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset A: ctrl=%h s_ready=%b busy=%b expected 0/1/0", a_ctrl, a_ready, a_busy);
        end else $display("PASS reset A");
        checks++;
        if (b_ctrl !== 32'h0 || b_ready !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset B: ctrl=%h s_ready=%b busy=%b expected 0/1/0", b_ctrl, b_ready, b_busy);
        end else $display("PASS reset B");
        rst = 1'b1;
        tick();
        model_ctrl = 32'h0;
    endtask

    task automatic test_basic();
        // target 0x0A010000, step 0x00A01000 from ctrl=0
        do_sample(32'h0A000000, 24'h001000, 8'h10, "basic");
    endtask

    task automatic test_neg_extreme();
        do_sample(32'h80000000, 24'hFFFFFF, 8'h80, "neg_extreme");
    endtask

    task automatic test_wrap();
        do_sample(32'hFFFFFF00, 24'h000123, 8'h00, "wrap_setup");
        do_sample(32'hFFFFFF00, 24'h000200, 8'h01, "wrap");
    endtask

    task automatic test_back_to_back();
        logic [31:0] t1, t2;
        int accepts, sec;
        logic acc, window_ok;
        wait_ready_a("b2b");
        t1 = calc_target(32'h40000000, 24'h001000, 8'h10);
        t2 = calc_target(32'h40000000, 24'h001000, 8'hF0);
        sb_q.push_back(t1);
        sb_q.push_back(t2);
        accepts = 0; sec = -1; window_ok = 1'b1;
        a_carrier = 32'h40000000; a_dev = 24'h001000; a_data = 8'h10; a_valid = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            acc = a_valid && a_ready;
            tick();                            // edge E(e)
            if (acc) begin
                accepts++;
                if (accepts == 1) a_data = 8'hF0;
                else begin
                    sec = e;
                    a_valid = 1'b0;
                end
            end
            if (e <= 17 && (a_ready !== 1'b0 || a_busy !== 1'b1)) window_ok = 1'b0;
            if (e == 18) begin
                checks++;
                if (a_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b s_ready after E18: got %b expected 1", a_ready);
                end
                sb_check("b2b_first", a_ctrl);
            end
            if (e == 37) sb_check("b2b_second", a_ctrl);
        end
        a_valid = 1'b0;
        checks++;
        if (!window_ok) begin
            errors++;
            $display("FAIL b2b busy window: s_ready/busy not 0/1 throughout E0..E17");
        end
        checks++;
        if (sec !== 19) begin
            errors++;
            $display("FAIL b2b second accept edge: got E%0d expected E19", sec);
        end
        checks++;
        if (accepts !== 2) begin
            errors++;
            $display("FAIL b2b accept count: got %0d expected 2", accepts);
        end
        $display("PASS-INFO b2b accepts=%0d second at E%0d", accepts, sec);
        model_ctrl = t2;
    endtask

    task automatic test_reset_mid_ramp();
        logic [31:0] tgt, stp, start;
        wait_ready_a("mid_reset");
        start = model_ctrl;
        tgt   = calc_target(32'h20000000, 24'h000800, 8'h40);
        stp   = calc_step(tgt, start, R);
        sb_q.push_back(tgt);
        a_carrier = 32'h20000000; a_dev = 24'h000800; a_data = 8'h40; a_valid = 1'b1;
        tick();                                // E0
        a_valid = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        checks++;
        if (a_ctrl !== start + 32'd5 * stp) begin
            errors++;
            $display("FAIL mid_reset ctrl E7: got %h expected %h", a_ctrl, start + 32'd5 * stp);
        end
        rst = 1'b0;
        tick();                                // E8 with reset
        checks++;
        if (a_ctrl !== 32'h0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset after E8: ctrl=%h busy=%b s_ready=%b expected 0/0/1",
                     a_ctrl, a_busy, a_ready);
        end else $display("PASS mid_reset cleared");
        rst = 1'b1;
        void'(sb_q.pop_front());               // in-flight sample discarded
        model_ctrl = 32'h0;
        tick();
        do_sample(32'h00100000, 24'h000100, 8'h02, "after_reset");
    endtask

    task automatic test_ramp0();
        logic [31:0] tgt;
        tgt = calc_target(32'h12345678, 24'h000001, 8'h01);
        sb_q.push_back(tgt);
        b_carrier = 32'h12345678; b_dev = 24'h000001; b_data = 8'h01; b_valid = 1'b1;
        tick();                                // E0
        b_valid = 1'b0;
        tick(); tick();                        // E1, E2
        checks++;
        if (b_ctrl !== 32'h0) begin
            errors++;
            $display("FAIL ramp0 ctrl E2: got %h expected 00000000", b_ctrl);
        end
        tick();                                // E3
        sb_check("ramp0", b_ctrl);
        checks++;
        if (b_ready !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL ramp0 after E3: s_ready=%b busy=%b expected 1/0", b_ready, b_busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        model_ctrl = 32'h0;
        test_reset();
        test_basic();
        test_neg_extreme();
        test_wrap();
        test_back_to_back();
        test_reset_mid_ramp();
        test_ramp0();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
